wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 DEPTH, 4, number of entries in the long-latency result FIFO (power of two, 2..8).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 core_we  input  1  single-cycle datapath writeback request.
REQ-005 core_addr  input  5  destination register for core write.
REQ-006 core_data  input  32  data for core write.
REQ-007 lu_valid  input  1  long-latency unit (mul/div/load) result valid.
REQ-008 lu_addr  input  5  destination register for lu result.
REQ-009 lu_data  input  32  lu result data.
REQ-010 lu_ready  output  1  FIFO can accept an lu result this cycle.
REQ-011 issue_valid  input  1  long-latency op issued this cycle; marks destination busy.
REQ-012 issue_addr  input  5  destination register of issued op.
REQ-013 rf_we  output  1  register-file write enable (registered).
REQ-014 rf_addr  output  5  register-file write address (registered).
REQ-015 rf_data  output  32  register-file write data (registered).
REQ-016 busy  output  32  scoreboard, bit n = register n has a pending long-latency write.
REQ-017 fifo_count  output  4  current FIFO occupancy, 0..DEPTH.

Function
REQ-018 The block SHALL accept an lu result on a rising edge where lu_valid && lu_ready, pushing {lu_addr, lu_data} to the FIFO tail.
REQ-019 lu_ready SHALL be combinational: 1 iff rst==1 and fifo_count < DEPTH; a pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-020 An accepted lu result with lu_addr==0 SHALL be consumed and discarded (not pushed, count unchanged).
REQ-021 Output arbitration per cycle, strict priority: (1) core_we && core_addr!=0 -> core write; (2) else FIFO non-empty -> pop head; (3) else idle.
REQ-022 Selected write SHALL appear on rf_we/rf_addr/rf_data exactly one cycle after selection (latency 1); idle cycle drives rf_we=0, rf_addr/rf_data hold last value.
REQ-023 core_we with core_addr==0 SHALL be ignored and SHALL NOT block a FIFO pop that cycle.
REQ-024 FIFO SHALL be in-order; entries never reordered or merged, including entries to the same register.
REQ-025 Push and pop in the same cycle SHALL leave fifo_count unchanged; read/write pointers wrap modulo DEPTH.
REQ-026 issue_valid with issue_addr!=0 SHALL set busy[issue_addr] at the next edge.
REQ-027 A FIFO pop SHALL clear busy[popped addr] at the same edge that registers the rf output.
REQ-028 Simultaneous set and clear of the same bit SHALL leave it set (set wins).
REQ-029 busy[0] SHALL be constant 0.
REQ-030 A core write to a busy register SHALL NOT clear its busy bit.
REQ-031 Core writes are never stalled; an lu source seeing lu_ready=0 SHALL hold lu_valid/lu_addr/lu_data stable.

Reset
REQ-032 While rst==0: rf_we=0, rf_addr=0, rf_data=0, busy=0, fifo_count=0, pointers=0, lu_ready=0, independent of clk.
REQ-033 Reset asserted mid-operation SHALL discard all FIFO contents and scoreboard state immediately.
REQ-034 First edge after rst deasserts SHALL operate normally; lu_ready=1 from deassertion.

Verification
REQ-035 Core only: core_we=1, addr=5, data=0xDEADBEEF -> next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; following idle cycle rf_we=0.
REQ-036 Priority: FIFO holds {7,0x11}, core writes {3,0x22} same cycle -> rf gets 3/0x22, then 7/0x11 next cycle; busy[7] clears with the 7 write.
REQ-037 Full: push 4 lu results with core_we=1 every cycle -> fifo_count=4, lu_ready=0; drop core_we -> entries drain in push order, one per cycle, count 3,2,1,0.
REQ-038 Scoreboard: issue_valid addr=9 -> busy=0x200; same-cycle pop of addr 9 and new issue to 9 -> busy[9] remains 1; issue addr 0 -> busy unchanged.
REQ-039 x0: lu result addr=0 accepted, count stays 0, no rf_we; core_we addr=0 with FIFO non-empty -> FIFO head written that cycle.
REQ-040 Reset mid-drain: fifo_count=3, pull rst low between edges -> all outputs 0 immediately; after release, rf_we stays 0 with no new input.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: core writes beat queued long-latency results; 1-cycle registered output.
// Core writes never stall; lu results back-pressure via lu_ready when the FIFO is full (no pop-through).
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_we,
    input  logic [4:0]  core_addr,
    input  logic [31:0] core_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic [31:0] busy,
    output logic [3:0]  fifo_count
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [4:0]    mem_addr_q [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]    count_q, count_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_addr_q, rf_addr_d;
    logic [31:0]   rf_data_q, rf_data_d;
    logic [31:0]   busy_q, busy_d;

    logic          push, pop, core_sel;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    // Readiness looks only at current occupancy, so a same-cycle pop never frees a slot.
    assign lu_ready  = rst && (count_q < DEPTH_C);
    assign push      = lu_valid && lu_ready && (lu_addr != 5'd0);
    assign core_sel  = core_we && (core_addr != 5'd0);
    assign pop       = !core_sel && (count_q != 4'd0);
    assign head_addr = mem_addr_q[rd_ptr_q];
    assign head_data = mem_data_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        busy_d    = busy_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase

        if (core_sel) begin
            rf_we_d   = 1'b1;
            rf_addr_d = core_addr;
            rf_data_d = core_data;
        end else if (pop) begin
            rf_we_d           = 1'b1;
            rf_addr_d         = head_addr;
            rf_data_d         = head_data;
            busy_d[head_addr] = 1'b0;
        end

        // Applied after the pop clear so a same-cycle reissue keeps the bit set.
        if (issue_valid && (issue_addr != 5'd0)) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= lu_addr;
            mem_data_q[wr_ptr_q] <= lu_data;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_addr    = rf_addr_q;
    assign rf_data    = rf_data_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule
